// File: rtl/compare_scheduler_if.sv
// ---------------------------------------------------------------------------
// compare_scheduler_if : request/response bundle for the compare scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface compare_scheduler_if #(
  parameter int WIDTH = 4
);
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic               less_than;
  logic               equal_to;
  logic               greater_than;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, less_than, equal_to, greater_than, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, less_than, equal_to, greater_than, busy
  );
endinterface

`default_nettype wire

// File: rtl/compare_scheduler.sv
// ---------------------------------------------------------------------------
// compare_scheduler : 4-way round-robin bit-serial (MSB-first) unsigned compare
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module compare_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  compare_scheduler_if.slave  bus
);

  localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       last_grant;
  logic [1:0]       grant;
  logic             grant_found;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDX_W-1:0] bit_idx;
  logic [1:0]       owner;
  logic             lt_q;
  logic             eq_q;
  logic             gt_q;
  logic             a_bit;
  logic             b_bit;
  logic             in_done;

  // Walk offsets high-to-low so the nearest requester after last_grant wins.
  always_comb begin
    logic [1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant       = last_grant + 2'd1;
    for (int off = 3; off >= 0; off--) begin
      cand = last_grant + 2'd1 + 2'(off);
      if (bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign accept = (state == IDLE) && grant_found && !reset;

  always_comb begin
    bus.req_ready = 4'b0000;
    if (accept) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

  assign a_bit = op_a[bit_idx];
  assign b_bit = op_b[bit_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if ((a_bit != b_bit) || (bit_idx == '0)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 2'd3;
      bit_idx    <= IDX_TOP;
      op_a       <= '0;
      op_b       <= '0;
      owner      <= 2'd0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
      gt_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= bus.req_a[int'(grant) * WIDTH +: WIDTH];
            op_b       <= bus.req_b[int'(grant) * WIDTH +: WIDTH];
            owner      <= grant;
            last_grant <= grant;
            bit_idx    <= IDX_TOP;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
          end
        end
        SHIFT: begin
          // First differing bit from the MSB decides the ordering.
          if (a_bit != b_bit) begin
            gt_q <= a_bit;
            lt_q <= ~a_bit;
          end else if (bit_idx == '0) begin
            eq_q <= 1'b1;
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_done          = (state == DONE);
  assign bus.rsp_valid    = in_done;
  assign bus.rsp_id       = in_done ? owner : 2'd0;
  assign bus.less_than    = in_done & lt_q;
  assign bus.equal_to     = in_done & eq_q;
  assign bus.greater_than = in_done & gt_q;
  assign bus.busy         = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_compare_scheduler.sv
// ---------------------------------------------------------------------------
// tb_compare_scheduler : directed self-checking bench for compare_scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_compare_scheduler;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  compare_scheduler_if #(.WIDTH(4)) bus ();

  compare_scheduler #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, check the grant, then time and check the result.
  task automatic run_txn(input int g, input logic [3:0] a, input logic [3:0] b,
                         input int exp_k, input logic [2:0] exp_flags,
                         input logic [3:0] mask, input bit hold);
    int k;
    bus.req_valid = mask;
    bus.req_a[g*4 +: 4] = a;
    bus.req_b[g*4 +: 4] = b;
    #1;
    check($sformatf("grant%0d", g), 32'(bus.req_ready), 32'(1) << g);
    step();
    check("ready_in_shift", 32'(bus.req_ready), 32'd0);
    if (!hold) bus.req_valid = 4'b0000;
    bus.req_a[g*4 +: 4] = ~a;
    bus.req_b[g*4 +: 4] = ~b;
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      step();
      k++;
    end
    check($sformatf("latency%0d", g), 32'(k), 32'(exp_k));
    check($sformatf("rsp_id%0d", g), 32'(bus.rsp_id), 32'(g));
    check($sformatf("flags%0d", g), 32'({bus.less_than, bus.equal_to, bus.greater_than}),
          32'(exp_flags));
    check("busy_done", 32'(bus.busy), 32'd1);
    if (bus.rsp_ready) begin
      step();
      check("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    bus.req_valid = 4'hF;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_flags", 32'({bus.less_than, bus.equal_to, bus.greater_than}), 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    bus.req_valid = 4'b0000;
    reset = 1'b0;
    step();
    step();
    check("idle_no_req", 32'(bus.busy), 32'd0);

    run_txn(0, 4'hA, 4'hB, 4, 3'b100, 4'b0001, 1'b0);
    run_txn(2, 4'h8, 4'h3, 1, 3'b001, 4'b0100, 1'b0);
    run_txn(1, 4'h5, 4'h5, 4, 3'b010, 4'b0010, 1'b0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_a = 16'h0000;
    bus.req_b = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      run_txn(i % 4, 4'h0, 4'h1, 4, 3'b100, 4'hF, 1'b1);
    end
    bus.req_valid = 4'b0000;
    step();

    bus.rsp_ready = 1'b0;
    run_txn(1, 4'h3, 4'h2, 4, 3'b001, 4'b0010, 1'b0);
    bus.req_valid = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_id", 32'(bus.rsp_id), 32'd1);
      check("hold_flags", 32'({bus.less_than, bus.equal_to, bus.greater_than}), 32'b001);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    step();
    check("release_valid", 32'(bus.rsp_valid), 32'd0);
    check("release_busy", 32'(bus.busy), 32'd0);
    bus.req_valid = 4'b0000;
    step();

    bus.req_valid = 4'b0100;
    bus.req_a[8 +: 4] = 4'h0;
    bus.req_b[8 +: 4] = 4'h0;
    #1;
    check("grant_req2", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = 4'b0000;
    step();
    step();
    check("mid_shift_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    bus.req_valid = 4'b1001;
    #1;
    check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    bus.req_valid = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("no_stale_rsp", 32'(seen), 32'd0);
    run_txn(0, 4'hF, 4'hE, 4, 3'b001, 4'b1001, 1'b1);
    check("next_grant3", 32'(bus.req_ready), 32'b1000);
    bus.req_valid = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
